tx2de5_serial: RTL and testbench

TX2DE5_SERIAL -- requirements
Module: tx2de5_serial

---
 rtl/tx2de5_pkg.sv | 31 +++
 rtl/tx2de5_baud.sv | 36 +++
 rtl/tx2de5_serial.sv | 106 ++++++++++
 tb/tb_tx2de5_serial.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tx2de5_pkg.sv
// Shared types and constants for the 2-of-5 serial transmitter.
// Frame states, the weighted 7-4-2-1-0 code table and the default bit period.
package tx2de5_pkg;

  localparam int unsigned ClksPerBitDefault = 50000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } state_t;

  localparam logic [4:0] CodeInvalid = 5'b00000;

  // Entry 9 first so that CodeTable[d] selects the code for digit d.
  localparam logic [9:0][4:0] CodeTable = {
    5'b10100, 5'b10010, 5'b10001, 5'b01100, 5'b01010,
    5'b01001, 5'b00110, 5'b00101, 5'b00011, 5'b11000
  };

  function automatic logic [4:0] encode_digit(input logic [3:0] d);
    logic [4:0] code;
    code = CodeInvalid;
    if (d <= 4'd9) begin
      code = CodeTable[d];
    end
    return code;
  endfunction

endpackage

// File: rtl/tx2de5_baud.sv
// Bit-period timer: counts 0..ClksPerBit-1 while enabled, ticks on the terminal count.
// The counter reloads to zero after the tick, so every period is exactly ClksPerBit cycles.
module tx2de5_baud #(
  parameter int unsigned ClksPerBit = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = en_i && (cnt_q == CntMax);
    cnt_d  = '0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tick_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tx2de5_serial.sv
// Serial 2-of-5 digit transmitter: start bit 1, code[4]..code[0], stop bit 0.
// Define ERR_FRAME_EN to send digits >9 as a full frame carrying code 00000.
module tx2de5_serial
  import tx2de5_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  input  logic       start,
  output logic       ready,
  output logic       tx_line,
  output logic [4:0] code_out,
  output logic       done,
  output logic       err
);

  state_t     state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [4:0] code_q, code_d;
  logic       err_q, err_d;
  logic       tick;
  logic       accept;
  logic       digit_bad;

  assign digit_bad = (digit > 4'd9);
  assign ready     = (state_q == StIdle);

`ifdef ERR_FRAME_EN
  assign accept = start && ready;
`else
  assign accept = start && ready && !digit_bad;
`endif

  tx2de5_baud #(
    .ClksPerBit(CLKS_PER_BIT)
  ) u_baud (
    .clk_i (clk),
    .rst_ni(rst_n),
    .en_i  (state_q != StIdle),
    .clr_i (accept),
    .tick_o(tick)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    code_d  = code_q;
    err_d   = start && ready && digit_bad;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StStart;
          bit_d   = 3'd0;
          code_d  = encode_digit(digit);
        end
      end
      StStart: begin
        if (tick) state_d = StData;
      end
      StData: begin
        if (tick) begin
          if (bit_q == 3'd4) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (tick) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is decoded from registered state only, so reset forces it low at once.
  always_comb begin
    tx_line = 1'b0;
    unique case (state_q)
      StStart: tx_line = 1'b1;
      StData:  tx_line = code_q[3'd4 - bit_q];
      default: tx_line = 1'b0;
    endcase
  end

  assign done     = (state_q == StStop) && tick;
  assign err      = err_q;
  assign code_out = code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bit_q   <= 3'd0;
      code_q  <= CodeInvalid;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_tx2de5_serial.sv
// Self-checking bench for tx2de5_serial with a 4-cycle bit period.
// Expected frames come from a weight-sum model of the 7-4-2-1-0 code.
module tb_tx2de5_serial;

  localparam int unsigned Cpb = 4;
  localparam int FrameLen = 7 * Cpb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] digit;
  logic       start;
  logic       ready;
  logic       tx_line;
  logic [4:0] code_out;
  logic       done;
  logic       err;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;
  logic [4:0]  last_code;

  always #5 clk = ~clk;

  tx2de5_serial #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .digit   (digit),
    .start   (start),
    .ready   (ready),
    .tx_line (tx_line),
    .code_out(code_out),
    .done    (done),
    .err     (err)
  );

  // Code whose two set weights sum to the digit (zero uses 7+4).
  function automatic logic [4:0] model_code(input int d);
    int w [5];
    int target;
    logic [4:0] r;
    w = '{7, 4, 2, 1, 0};
    r = 5'b00000;
    if (d > 9) return r;
    target = (d == 0) ? 11 : d;
    for (int i = 0; i < 5; i++) begin
      for (int j = i + 1; j < 5; j++) begin
        if (w[i] + w[j] == target) begin
          r = 5'b00000;
          r[4-i] = 1'b1;
          r[4-j] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // Line level on frame cycle k (1-based).
  function automatic logic model_bit(input logic [4:0] c, input int k);
    int slot;
    slot = (k - 1) / Cpb;
    if (slot == 0) return 1'b1;
    if (slot <= 5) return c[5-slot];
    return 1'b0;
  endfunction

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of frame cycle 29.
  task automatic send_frame(input logic [3:0] d, input logic hold);
    logic [4:0] c;
    logic       bad;
    bad = (d > 4'd9);
    c   = model_code(int'(d));
    chk_b("idle_ready", ready, 1'b1);
    digit = d;
    start = 1'b1;
    @(negedge clk);
`ifndef ERR_FRAME_EN
    if (bad) begin
      chk_b("bad_err", err, 1'b1);
      chk_b("bad_ready", ready, 1'b1);
      chk_b("bad_tx", tx_line, 1'b0);
      chk_v("bad_code_kept", code_out, last_code);
      start = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk_b("bad_err_once", err, 1'b0);
        chk_b("bad_no_tx", tx_line, 1'b0);
        chk_b("bad_ready_hold", ready, 1'b1);
      end
      return;
    end
`endif
    chk_b("err_cycle1", err, bad);
    if (!hold) start = 1'b0;
    for (int k = 1; k <= FrameLen; k++) begin
      if (k > 1) begin
        @(negedge clk);
        chk_b("err_quiet", err, 1'b0);
      end
      chk_b("tx_bit", tx_line, model_bit(c, k));
      chk_b("done", done, (k == FrameLen));
      chk_b("busy", ready, 1'b0);
      chk_v("code_out", code_out, c);
      // Mid-frame digit changes and start pulses must not disturb the frame.
      digit = 4'($urandom_range(0, 15));
      if (!hold) start = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    chk_b("ready_after", ready, 1'b1);
    chk_b("tx_idle", tx_line, 1'b0);
    chk_b("done_once", done, 1'b0);
    last_code = c;
    if (!hold) start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] d;
    rst_n = 1'b0;
    start = 1'b0;
    digit = 4'd0;
    last_code = 5'b00000;
    #1;
    chk_b("rst_tx", tx_line, 1'b0);
    chk_b("rst_ready", ready, 1'b1);
    chk_v("rst_code", code_out, 5'b00000);
    chk_b("rst_done", done, 1'b0);
    chk_b("rst_err", err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send_frame(4'd7, 1'b0);

    for (int i = 0; i <= 9; i++) begin
      send_frame(4'(i), 1'b0);
      chk_b("two_ones", ($countones(code_out) == 2), 1'b1);
    end

    send_frame(4'd12, 1'b0);

    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk_b("gap_tx", tx_line, 1'b0);
        chk_b("gap_ready", ready, 1'b1);
      end
      d = 4'($urandom_range(0, 15));
      send_frame(d, 1'b0);
    end

    // Held start: frames separated by exactly one idle cycle.
    send_frame(4'd3, 1'b1);
    send_frame(4'd3, 1'b1);
    start = 1'b0;
    @(negedge clk);
    chk_b("b2b_stop_ready", ready, 1'b1);
    chk_b("b2b_stop_tx", tx_line, 1'b0);

    // Reset at frame cycle 10 aborts without a done pulse.
    chk_b("pre_rst_ready", ready, 1'b1);
    digit = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      chk_b("pre_rst_tx", tx_line, model_bit(model_code(9), k));
    end
    rst_n = 1'b0;
    #1;
    chk_b("abort_tx", tx_line, 1'b0);
    chk_b("abort_ready", ready, 1'b1);
    chk_v("abort_code", code_out, 5'b00000);
    chk_b("abort_done", done, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk_b("abort_no_done", done, 1'b0);
      chk_b("abort_idle", ready, 1'b1);
    end
    rst_n = 1'b1;
    last_code = 5'b00000;
    @(negedge clk);
    send_frame(4'd5, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
